// File: rtl/rr_arb_mux_4_1.sv
// Round-robin arbiter over four valid/ready channels feeding a registered 4:1 mux.
// The winning channel's data and index leave through a single valid/ready output stage.
module rr_arb_mux_4_1 #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [3:0]       i_in_valid,
    output logic [3:0]       o_in_ready,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic [WIDTH-1:0] i_d2,
    input  logic [WIDTH-1:0] i_d3,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [1:0]       o_out_sel
);

    logic [1:0]       r_ptr;
    logic             r_vld_p1;
    logic [WIDTH-1:0] r_data_p1;
    logic [1:0]       r_sel_p1;

    logic             w_load_en;
    logic             w_gnt_any;
    logic [1:0]       w_gnt_idx;
    logic [1:0]       w_idx;
    logic [3:0]       w_grant;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux_data;

    // The output slot can take a new beat when empty or being drained this cycle.
    assign w_load_en = !r_vld_p1 || i_out_ready;

    // Scan ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap); the first valid channel wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = 2'd0;
        w_idx     = 2'd0;
        w_grant   = 4'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + k[1:0];
            if (!w_gnt_any && i_in_valid[w_idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        w_grant[w_gnt_idx] = w_gnt_any;
    end

    assign o_in_ready = (w_load_en && !i_rst) ? w_grant : 4'd0;
    assign w_accept   = |o_in_ready;

    always_comb begin
        w_mux_data = i_d0;
        case (w_gnt_idx)
            2'd0: w_mux_data = i_d0;
            2'd1: w_mux_data = i_d1;
            2'd2: w_mux_data = i_d2;
            2'd3: w_mux_data = i_d3;
            default: w_mux_data = i_d0;
        endcase
    end

    // Stage p1: output register; rst wins over both accept and pop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr     <= 2'd0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_sel_p1  <= 2'd0;
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_data_p1 <= w_mux_data;
            r_sel_p1  <= w_gnt_idx;
            r_ptr     <= w_gnt_idx + 2'd1;
        end else if (i_out_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign o_out_valid = r_vld_p1;
    assign o_out_data  = r_data_p1;
    assign o_out_sel   = r_sel_p1;

endmodule

// File: tb/tb_rr_arb_mux_4_1.sv
// Directed bench for rr_arb_mux_4_1: reset, rotation, wrap, backpressure, mid-stream reset, idle drain.
module tb_rr_arb_mux_4_1;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [3:0]       in_valid;
    logic [3:0]       in_ready;
    logic [WIDTH-1:0] d0, d1, d2, d3;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    int total = 0;
    int bad   = 0;

    rr_arb_mux_4_1 #(.WIDTH(WIDTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_d0        (d0),
        .i_d1        (d1),
        .i_d2        (d2),
        .i_d3        (d3),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_sel   (out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [3:0] exp_rdy [5];
    logic [1:0] exp_sel [5];
    logic [3:0] exp_dat [5];

    initial begin
        exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd1};

        // 1: reset with all channels requesting
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        settle();
        chk("rst_in_ready", in_ready, 4'd0);
        tick();
        tick();
        chk("rst_in_ready2", in_ready, 4'd0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sel", out_sel, 2'd0);
        chk("rst_out_data", out_data, 4'd0);
        rst = 1'b0; in_valid = 4'h0;
        tick();
        chk("rel_out_valid", out_valid, 1'b0);
        chk("rel_out_sel", out_sel, 2'd0);
        chk("rel_out_data", out_data, 4'd0);

        // 2: all valid, full rotation without gaps
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("rot_rdy%0d", i), in_ready, exp_rdy[i]);
            tick();
            chk($sformatf("rot_vld%0d", i), out_valid, 1'b1);
            chk($sformatf("rot_sel%0d", i), out_sel, exp_sel[i]);
            chk($sformatf("rot_dat%0d", i), out_data, exp_dat[i]);
        end

        // 3: lone ch2, then ch1+ch3 with pointer wrapping through 3 -> 0
        in_valid = 4'b0100; d2 = 4'hA;
        settle();
        chk("ch2_rdy", in_ready, 4'b0100);
        tick();
        chk("ch2_sel", out_sel, 2'd2);
        chk("ch2_dat", out_data, 4'hA);
        in_valid = 4'b1010; d1 = 4'd5; d3 = 4'd7;
        settle();
        chk("wrap_rdy3", in_ready, 4'b1000);
        tick();
        chk("wrap_sel3", out_sel, 2'd3);
        chk("wrap_dat3", out_data, 4'd7);
        settle();
        chk("wrap_rdy1", in_ready, 4'b0010);
        tick();
        chk("wrap_sel1", out_sel, 2'd1);
        chk("wrap_dat1", out_data, 4'd5);

        // 4: backpressure for 3 cycles with all channels valid (ptr=2)
        out_ready = 1'b0; in_valid = 4'hF;
        d0 = 4'd1; d1 = 4'd2; d2 = 4'd3; d3 = 4'd4;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("bp_rdy%0d", i), in_ready, 4'd0);
            tick();
            chk($sformatf("bp_vld%0d", i), out_valid, 1'b1);
            chk($sformatf("bp_sel%0d", i), out_sel, 2'd1);
            chk($sformatf("bp_dat%0d", i), out_data, 4'd5);
        end
        out_ready = 1'b1;
        settle();
        chk("bp_rel_rdy", in_ready, 4'b0100);
        tick();
        chk("bp_rel_vld", out_valid, 1'b1);
        chk("bp_rel_sel", out_sel, 2'd2);
        chk("bp_rel_dat", out_data, 4'd3);

        // 5: bring ptr to 2 with a held beat, then reset mid-stream
        in_valid = 4'b0010;
        tick();
        chk("pre5_sel", out_sel, 2'd1);
        rst = 1'b1; in_valid = 4'hF;
        settle();
        chk("mrst_rdy", in_ready, 4'd0);
        tick();
        chk("mrst_vld", out_valid, 1'b0);
        chk("mrst_sel", out_sel, 2'd0);
        chk("mrst_dat", out_data, 4'd0);
        rst = 1'b0;
        settle();
        chk("mrst_first_rdy", in_ready, 4'b0001);
        tick();
        chk("mrst_first_vld", out_valid, 1'b1);
        chk("mrst_first_sel", out_sel, 2'd0);
        chk("mrst_first_dat", out_data, 4'd1);

        // 6: idle drain of a held beat leaves ptr at 1
        in_valid = 4'h0;
        settle();
        chk("idle_rdy", in_ready, 4'd0);
        tick();
        chk("idle_vld", out_valid, 1'b0);
        in_valid = 4'hF;
        settle();
        chk("idle_ptr_rdy", in_ready, 4'b0010);
        tick();
        chk("idle_ptr_sel", out_sel, 2'd1);
        chk("idle_ptr_dat", out_data, 4'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
